sprite_rom_scheduler: RTL and testbench
=======================================

// Module: sprite_rom_scheduler
// PURPOSE
//  Time-multiplexes one single-port sprite ROM (11-bit addr, 6-bit RRGGBB, 1-clk registered read)
//  between two player sprites. Per pixel: hit-tests both players, issues two ROM reads on
//  alternate clocks, composites with P1 priority and colour-key transparency.
//  Sits between the VGA timing counters and the background/sprite mixer.
// PARAMETERS
//  SPR_W   30      sprite width in pixels
//  SPR_H   46      sprite height in pixels (SPR_W*SPR_H <= 2**ADDR_W)
//  ADDR_W  11      ROM address width
//  RGB_W   6       colour width (RRGGBB)
//  TRANSP  6'h33   colour key treated as transparent (magenta)
// PORTS
//  clk          in   1       system clock (2x pixel rate)
//  rst_n        in   1       asynchronous active-low reset
//  pix_en       in   1       pixel strobe, one clk in every two
//  frame_start  in   1       1-clk pulse at top of frame; loads player shadow regs
//  hcount       in   10      current pixel column
//  vcount       in   10      current pixel row
//  p1_x, p1_y   in   10 ea   P1 top-left position
//  p1_flip      in   1       P1 horizontal mirror
//  p1_en        in   1       P1 visible
//  p2_x, p2_y, p2_flip, p2_en  same for P2
//  rom_addr     out  ADDR_W  registered ROM address
//  rom_rgb      in   RGB_W   ROM data, valid 1 clk after rom_addr
//  spr_valid    out  1       opaque sprite pixel present
//  spr_rgb      out  RGB_W   composited colour (0 when !spr_valid)
//  spr_owner    out  1       0=P1, 1=P2 (0 when !spr_valid)
// BEHAVIOUR
//  - Reset: rom_addr=0, spr_valid=0, spr_rgb=0, spr_owner=0, phase=0, all shadow regs 0 (both players off).
//  - Shadow regs: x/y/flip/en for both players load only on frame_start; mid-frame input changes are invisible.
//  - Phase FSM: IDLE/A -> B. In A with pix_en=1: latch hcount/vcount; register P1 addr+hit; go B.
//    In B: register P2 addr+hit; return A. pix_en while in B is ignored. No pix_en in A: stay in A, pipe drains.
//  - Hit: dx=hcount-px, dy=vcount-py in 11 bits; hit iff en && no borrow && dx<SPR_W && dy<SPR_H.
//  - Addr: col = flip ? SPR_W-1-dx : dx; addr = dy*SPR_W + col (constant multiply, ADDR_W bits).
//    No hit -> rom_addr=0 and the hit flag forces that read to transparent.
//  - Timeline (pix_en sampled at edge E0): E0 P1 addr out; E1 P2 addr out; E2 capture P1 rgb;
//    E3 capture P2 rgb and register outputs. Latency 3 clks; outputs hold 2 clks. Back-to-back pixels fully pipelined.
//  - Opaque = hit && rgb!=TRANSP. Composite: P1 opaque -> P1; else P2 opaque -> P2; else valid=0, rgb=0.
//  - Hit/flip flags pipeline alongside addresses. Overlapping sprites and identical positions are legal.
//  - frame_start coincident with pix_en: the new shadow values apply from the next pixel.
//  - Reset mid-pixel: in-flight reads are discarded; first output after release comes 3 clks after the first pix_en.
// STRUCTURE
//  - sprite_pkg: SPR_W/SPR_H/TRANSP defaults, typedef player_t {x,y,flip,en}, enum owner_e {P1,P2}, enum phase_e {PH_A,PH_B}.
//  - Sub-module sprite_hit_addr (combinational hit test + address calc), one instance muxed by phase.
//  - Top: shadow regs, phase FSM, 2-stage flag pipeline, capture regs, composite output regs.
// TESTING
//  1. P1 (100,50) en, no flip; hcount=105, vcount=52 -> rom_addr=65 at E0; ROM=6'h0C -> spr_rgb=0C, owner=0 at E3.
//  2. Same with p1_flip=1 -> rom_addr=84 (2*30+24).
//  3. hcount=99 or 130, or vcount=96 -> no hit, rom_addr=0, spr_valid=0; p1_x=0, hcount=0 -> hit, addr=row*30.
//  4. P1 and P2 both at (200,100), hcount=200, vcount=100: P1 data=TRANSP, P2=6'h30 -> rgb=30, owner=1;
//     P1=6'h03 -> rgb=03, owner=0.
//  5. p1_x changed mid-frame with no frame_start -> addresses unchanged; after frame_start the new position is used.
//  6. Continuous pix_en stream with a reset pulse mid-pixel -> outputs go to 0 asynchronously; stray pix_en in phase B ignored.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sizes, player descriptor and enums for the two-player sprite ROM scheduler.
package sprite_pkg;

    localparam int unsigned SPR_W   = 30;
    localparam int unsigned SPR_H   = 46;
    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned RGB_W   = 6;
    localparam int unsigned COORD_W = 10;

    localparam logic [RGB_W-1:0] TRANSP = 6'h33;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               flip;
        logic               en;
    } player_t;

    typedef enum logic {
        P1 = 1'b0,
        P2 = 1'b1
    } owner_e;

    typedef enum logic {
        PH_A = 1'b0,
        PH_B = 1'b1
    } phase_e;

endpackage

// File: rtl/sprite_hit_addr.sv
// Combinational hit test and ROM address for one player against one pixel position.
module sprite_hit_addr
    import sprite_pkg::*;
(
    input  player_t            player_i,
    input  logic [COORD_W-1:0] hcount_i,
    input  logic [COORD_W-1:0] vcount_i,
    output logic               hit_o_c,
    output logic [ADDR_W-1:0]  addr_o_c
);

    localparam int unsigned DW = COORD_W + 1;

    logic [DW-1:0] dx;
    logic [DW-1:0] dy;
    logic [DW-1:0] col;

    // The extra MSB of each difference is the borrow: pixel left of / above the sprite.
    always_comb begin
        dx       = {1'b0, hcount_i} - {1'b0, player_i.x};
        dy       = {1'b0, vcount_i} - {1'b0, player_i.y};
        hit_o_c  = player_i.en && !dx[DW-1] && !dy[DW-1]
                   && (dx < DW'(SPR_W)) && (dy < DW'(SPR_H));
        col      = player_i.flip ? (DW'(SPR_W - 1) - dx) : dx;
        addr_o_c = (ADDR_W'(dy) * ADDR_W'(SPR_W)) + ADDR_W'(col);
    end

endmodule

// File: rtl/sprite_rom_scheduler.sv
// Shares one registered single-port sprite ROM between two players: two reads per pixel,
// then P1-priority composite with colour-key transparency, 3 clocks after the pixel strobe.
module sprite_rom_scheduler
    import sprite_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_en_i,
    input  logic               frame_start_i,
    input  logic [COORD_W-1:0] hcount_i,
    input  logic [COORD_W-1:0] vcount_i,
    input  logic [COORD_W-1:0] p1_x_i,
    input  logic [COORD_W-1:0] p1_y_i,
    input  logic               p1_flip_i,
    input  logic               p1_en_i,
    input  logic [COORD_W-1:0] p2_x_i,
    input  logic [COORD_W-1:0] p2_y_i,
    input  logic               p2_flip_i,
    input  logic               p2_en_i,
    output logic [ADDR_W-1:0]  rom_addr_o,
    input  logic [RGB_W-1:0]   rom_rgb_i,
    output logic               spr_valid_o,
    output logic [RGB_W-1:0]   spr_rgb_o,
    output logic               spr_owner_o
);

    phase_e             phase_q, phase_d;
    player_t            p1_q, p2_q;
    player_t            p2_cur_q, p2_cur_d;
    logic [COORD_W-1:0] h_lat_q, h_lat_d;
    logic [COORD_W-1:0] v_lat_q, v_lat_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;

    logic               iss_vld_q, iss_vld_d;
    logic               iss_hit_q, iss_hit_d;
    owner_e             iss_own_q, iss_own_d;
    logic               dat_vld_q, dat_vld_d;
    logic               dat_hit_q, dat_hit_d;
    owner_e             dat_own_q, dat_own_d;

    logic               p1_op_q, p1_op_d;
    logic [RGB_W-1:0]   p1_rgb_q, p1_rgb_d;
    logic               spr_valid_q, spr_valid_d;
    logic [RGB_W-1:0]   spr_rgb_q, spr_rgb_d;
    owner_e             spr_owner_q, spr_owner_d;

    player_t            ha_player;
    logic [COORD_W-1:0] ha_h;
    logic [COORD_W-1:0] ha_v;
    logic               ha_hit;
    logic [ADDR_W-1:0]  ha_addr;
    logic               rd_opaque;

    // Phase A tests P1 against the live counters; phase B tests P2 against the latched pixel.
    assign ha_player = (phase_q == PH_A) ? p1_q     : p2_cur_q;
    assign ha_h      = (phase_q == PH_A) ? hcount_i : h_lat_q;
    assign ha_v      = (phase_q == PH_A) ? vcount_i : v_lat_q;

    sprite_hit_addr u_hit_addr (
        .player_i (ha_player),
        .hcount_i (ha_h),
        .vcount_i (ha_v),
        .hit_o_c  (ha_hit),
        .addr_o_c (ha_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_q <= '0;
            p2_q <= '0;
        end else if (frame_start_i) begin
            p1_q <= '{x: p1_x_i, y: p1_y_i, flip: p1_flip_i, en: p1_en_i};
            p2_q <= '{x: p2_x_i, y: p2_y_i, flip: p2_flip_i, en: p2_en_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= PH_A;
            p2_cur_q    <= '0;
            h_lat_q     <= '0;
            v_lat_q     <= '0;
            rom_addr_q  <= '0;
            iss_vld_q   <= 1'b0;
            iss_hit_q   <= 1'b0;
            iss_own_q   <= P1;
            dat_vld_q   <= 1'b0;
            dat_hit_q   <= 1'b0;
            dat_own_q   <= P1;
            p1_op_q     <= 1'b0;
            p1_rgb_q    <= '0;
            spr_valid_q <= 1'b0;
            spr_rgb_q   <= '0;
            spr_owner_q <= P1;
        end else begin
            phase_q     <= phase_d;
            p2_cur_q    <= p2_cur_d;
            h_lat_q     <= h_lat_d;
            v_lat_q     <= v_lat_d;
            rom_addr_q  <= rom_addr_d;
            iss_vld_q   <= iss_vld_d;
            iss_hit_q   <= iss_hit_d;
            iss_own_q   <= iss_own_d;
            dat_vld_q   <= dat_vld_d;
            dat_hit_q   <= dat_hit_d;
            dat_own_q   <= dat_own_d;
            p1_op_q     <= p1_op_d;
            p1_rgb_q    <= p1_rgb_d;
            spr_valid_q <= spr_valid_d;
            spr_rgb_q   <= spr_rgb_d;
            spr_owner_q <= spr_owner_d;
        end
    end

    always_comb begin
        phase_d     = phase_q;
        p2_cur_d    = p2_cur_q;
        h_lat_d     = h_lat_q;
        v_lat_d     = v_lat_q;
        rom_addr_d  = rom_addr_q;
        iss_vld_d   = 1'b0;
        iss_hit_d   = 1'b0;
        iss_own_d   = P1;
        dat_vld_d   = iss_vld_q;
        dat_hit_d   = iss_hit_q;
        dat_own_d   = iss_own_q;
        p1_op_d     = p1_op_q;
        p1_rgb_d    = p1_rgb_q;
        spr_valid_d = spr_valid_q;
        spr_rgb_d   = spr_rgb_q;
        spr_owner_d = spr_owner_q;
        rd_opaque   = dat_hit_q && (rom_rgb_i != TRANSP);

        // Issue side: P2 shadow is snapshotted with the pixel so a coincident frame_start waits a pixel.
        unique case (phase_q)
            PH_A: begin
                if (pix_en_i) begin
                    h_lat_d    = hcount_i;
                    v_lat_d    = vcount_i;
                    p2_cur_d   = p2_q;
                    rom_addr_d = ha_hit ? ha_addr : '0;
                    iss_vld_d  = 1'b1;
                    iss_hit_d  = ha_hit;
                    iss_own_d  = P1;
                    phase_d    = PH_B;
                end
            end
            PH_B: begin
                rom_addr_d = ha_hit ? ha_addr : '0;
                iss_vld_d  = 1'b1;
                iss_hit_d  = ha_hit;
                iss_own_d  = P2;
                phase_d    = PH_A;
            end
            default: phase_d = PH_A;
        endcase

        // Data side: hold P1's read, then composite when P2's read arrives.
        if (dat_vld_q) begin
            if (dat_own_q == P1) begin
                p1_op_d  = rd_opaque;
                p1_rgb_d = rom_rgb_i;
            end else if (p1_op_q) begin
                spr_valid_d = 1'b1;
                spr_rgb_d   = p1_rgb_q;
                spr_owner_d = P1;
            end else if (rd_opaque) begin
                spr_valid_d = 1'b1;
                spr_rgb_d   = rom_rgb_i;
                spr_owner_d = P2;
            end else begin
                spr_valid_d = 1'b0;
                spr_rgb_d   = '0;
                spr_owner_d = P1;
            end
        end
    end

    assign rom_addr_o  = rom_addr_q;
    assign spr_valid_o = spr_valid_q;
    assign spr_rgb_o   = spr_rgb_q;
    assign spr_owner_o = spr_owner_q;

endmodule

// File: tb/tb_sprite_rom_scheduler.sv
// Scoreboard bench for sprite_rom_scheduler with a registered-read ROM model.
module tb_sprite_rom_scheduler;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       flip;
        logic       en;
    } tb_player_t;

    typedef struct {
        int          due;
        logic [10:0] addr;
    } addr_exp_t;

    typedef struct {
        int         due;
        logic       valid;
        logic [5:0] rgb;
        logic       owner;
    } pix_exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  hcount = '0;
    logic [9:0]  vcount = '0;
    logic [9:0]  p1_x = '0, p1_y = '0, p2_x = '0, p2_y = '0;
    logic        p1_flip = 1'b0, p1_en = 1'b0, p2_flip = 1'b0, p2_en = 1'b0;
    logic [10:0] rom_addr;
    logic [5:0]  rom_rgb = '0;
    logic        spr_valid;
    logic [5:0]  spr_rgb;
    logic        spr_owner;

    logic [5:0]  rom [2048];
    tb_player_t  sh1 = '0, sh2 = '0;
    addr_exp_t   aq[$];
    pix_exp_t    pq[$];
    addr_exp_t   ae;
    pix_exp_t    pe;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    sprite_rom_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pix_en_i      (pix_en),
        .frame_start_i (frame_start),
        .hcount_i      (hcount),
        .vcount_i      (vcount),
        .p1_x_i        (p1_x),
        .p1_y_i        (p1_y),
        .p1_flip_i     (p1_flip),
        .p1_en_i       (p1_en),
        .p2_x_i        (p2_x),
        .p2_y_i        (p2_y),
        .p2_flip_i     (p2_flip),
        .p2_en_i       (p2_en),
        .rom_addr_o    (rom_addr),
        .rom_rgb_i     (rom_rgb),
        .spr_valid_o   (spr_valid),
        .spr_rgb_o     (spr_rgb),
        .spr_owner_o   (spr_owner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_rgb <= rom[rom_addr];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_hit(input tb_player_t p, input int h, input int v,
                             output bit hit, output logic [10:0] addr);
        int dx, dy, col;
        dx  = h - int'(p.x);
        dy  = v - int'(p.y);
        hit = p.en && dx >= 0 && dx < 30 && dy >= 0 && dy < 46;
        col = p.flip ? (29 - dx) : dx;
        addr = hit ? 11'(dy * 30 + col) : 11'd0;
    endtask

    // One pixel: strobe for one clock, optional stray strobe in the second clock.
    task automatic drive_pixel(input int h, input int v, input bit fs, input bit stray);
        bit          hit1, hit2, op1, op2;
        logic [10:0] a1, a2;
        logic [5:0]  d1, d2;
        pix_exp_t    e;
        @(negedge clk);
        pix_en = 1'b1; hcount = 10'(h); vcount = 10'(v); frame_start = fs;
        model_hit(sh1, h, v, hit1, a1);
        model_hit(sh2, h, v, hit2, a2);
        d1 = rom[a1];
        d2 = rom[a2];
        op1 = hit1 && d1 != 6'h33;
        op2 = hit2 && d2 != 6'h33;
        e.due = cyc + 4;
        if (op1)      begin e.valid = 1'b1; e.rgb = d1;   e.owner = 1'b0; end
        else if (op2) begin e.valid = 1'b1; e.rgb = d2;   e.owner = 1'b1; end
        else          begin e.valid = 1'b0; e.rgb = 6'h0; e.owner = 1'b0; end
        aq.push_back('{due: cyc + 1, addr: a1});
        aq.push_back('{due: cyc + 2, addr: a2});
        pq.push_back(e);
        if (fs) begin
            sh1 = '{p1_x, p1_y, p1_flip, p1_en};
            sh2 = '{p2_x, p2_y, p2_flip, p2_en};
        end
        @(negedge clk);
        pix_en = stray; frame_start = 1'b0;
    endtask

    task automatic load_frame();
        @(negedge clk);
        pix_en = 1'b0; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        sh1 = '{p1_x, p1_y, p1_flip, p1_en};
        sh2 = '{p2_x, p2_y, p2_flip, p2_en};
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        pix_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (aq.size() > 0 && aq[0].due == cyc) begin
            ae = aq.pop_front();
            check_val("rom_addr", 32'(rom_addr), 32'(ae.addr));
        end
        if (pq.size() > 0 && pq[0].due == cyc) begin
            pe = pq.pop_front();
            check_val("spr_valid", 32'(spr_valid), 32'(pe.valid));
            check_val("spr_rgb", 32'(spr_rgb), 32'(pe.rgb));
            check_val("spr_owner", 32'(spr_owner), 32'(pe.owner));
        end
    end

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 6'((i * 7 + 1) % 64);
        rom[65] = 6'h0C;
        rom[84] = 6'h2A;

        #12;
        check_val("reset_addr", 32'(rom_addr), 32'd0);
        check_val("reset_valid", 32'(spr_valid), 32'd0);
        check_val("reset_rgb", 32'(spr_rgb), 32'd0);
        check_val("reset_owner", 32'(spr_owner), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Shadow regs still zero: nobody is visible.
        drive_pixel(105, 52, 1'b0, 1'b0);

        p1_x = 10'd100; p1_y = 10'd50; p1_en = 1'b1;
        load_frame();
        drive_pixel(105, 52, 1'b0, 1'b0);
        p1_flip = 1'b1;
        load_frame();
        drive_pixel(105, 52, 1'b0, 1'b0);
        p1_flip = 1'b0;
        load_frame();
        drive_pixel(99, 52, 1'b0, 1'b0);
        drive_pixel(130, 52, 1'b0, 1'b0);
        drive_pixel(105, 96, 1'b0, 1'b0);
        drive_pixel(129, 95, 1'b0, 1'b0);
        drive_pixel(100, 50, 1'b0, 1'b0);

        p1_x = 10'd0;
        load_frame();
        drive_pixel(0, 60, 1'b0, 1'b0);
        drive_pixel(29, 60, 1'b0, 1'b0);
        idle(3);

        // Overlap at identical positions; P2 mirrored so its read hits a different word.
        p1_x = 10'd200; p1_y = 10'd100;
        p2_x = 10'd200; p2_y = 10'd100; p2_flip = 1'b1; p2_en = 1'b1;
        rom[0] = 6'h33; rom[29] = 6'h30;
        load_frame();
        drive_pixel(200, 100, 1'b0, 1'b0);
        idle(4);
        rom[0] = 6'h03;
        drive_pixel(200, 100, 1'b0, 1'b0);
        idle(4);
        rom[0] = 6'h33; rom[29] = 6'h33;
        drive_pixel(200, 100, 1'b0, 1'b0);
        idle(4);
        rom[0] = 6'h03; rom[29] = 6'h30;
        drive_pixel(215, 120, 1'b0, 1'b0);
        drive_pixel(229, 145, 1'b0, 1'b0);

        // Mid-frame move is invisible until frame_start; coincident frame_start affects the next pixel.
        p1_x = 10'd300;
        drive_pixel(205, 101, 1'b0, 1'b0);
        drive_pixel(305, 101, 1'b0, 1'b0);
        drive_pixel(305, 101, 1'b1, 1'b0);
        drive_pixel(305, 101, 1'b0, 1'b0);
        drive_pixel(205, 101, 1'b0, 1'b0);

        // Continuous stream with stray strobes, then an asynchronous reset mid-pixel.
        drive_pixel(310, 110, 1'b0, 1'b1);
        drive_pixel(311, 110, 1'b0, 1'b1);
        drive_pixel(312, 111, 1'b0, 1'b1);
        @(negedge clk);
        pix_en = 1'b0;
        #2;
        rst_n = 1'b0;
        aq.delete();
        pq.delete();
        sh1 = '0;
        sh2 = '0;
        #1;
        check_val("async_rst_addr", 32'(rom_addr), 32'd0);
        check_val("async_rst_valid", 32'(spr_valid), 32'd0);
        check_val("async_rst_rgb", 32'(spr_rgb), 32'd0);
        check_val("async_rst_owner", 32'(spr_owner), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        drive_pixel(305, 101, 1'b0, 1'b1);
        load_frame();
        drive_pixel(305, 101, 1'b0, 1'b1);
        drive_pixel(215, 120, 1'b0, 1'b1);
        drive_pixel(301, 105, 1'b0, 1'b0);
        idle(6);

        check_val("drain_addr_q", 32'(aq.size()), 32'd0);
        check_val("drain_pix_q", 32'(pq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
